// File: rtl/str_check_sched.sv
// str_check_sched: two-requester string checker with round-robin ownership.
// A granted requester streams ASCII characters; the recognizer checks that the
// string alternates single digit / single non-digit, starting and ending with
// a digit. A one-cycle result strobe follows the last character.
// Optional build macro: STR_CHECK_SCHED_TIMEOUT_EN adds a 16-cycle idle
// timeout in STREAM that reports an aborted string.
//
// state  | meaning
// IDLE   | no owner; waiting for any valid, then grant
// STREAM | owner's ready is high; characters are accepted and checked
// REPORT | one-cycle result strobe, then hand priority to the other requester

module str_check_sched (
    input  logic       clk,
    input  logic       clr,
    input  logic       in0_valid,
    input  logic [7:0] in0_data,
    input  logic       in0_last,
    output logic       in0_ready,
    input  logic       in1_valid,
    input  logic [7:0] in1_data,
    input  logic       in1_last,
    output logic       in1_ready,
    output logic       res_valid,
    output logic       res_ok,
    output logic       res_id,
    output logic [7:0] res_len,
    output logic       res_abort,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, STREAM, REPORT} state_t;
    typedef enum logic [1:0] {R_START, R_DIG, R_SEP, R_ERR} rec_t;

    state_t     state_q, state_d;
    rec_t       rec_q, rec_d, rec_nxt;
    logic       rr_ptr_q, rr_ptr_d;
    logic       owner_q, owner_d;
    logic [7:0] len_q, len_d;

    logic       sel_valid;
    logic [7:0] sel_data;
    logic       sel_last;
    logic       is_digit;
    logic       xfer;

`ifdef STR_CHECK_SCHED_TIMEOUT_EN
    logic [3:0] idle_cnt_q, idle_cnt_d;
    logic       abort_q, abort_d;
`endif

    assign sel_valid = owner_q ? in1_valid : in0_valid;
    assign sel_data  = owner_q ? in1_data  : in0_data;
    assign sel_last  = owner_q ? in1_last  : in0_last;
    assign is_digit  = (sel_data >= 8'h30) && (sel_data <= 8'h39);
    assign xfer      = (state_q == STREAM) && sel_valid;

    // Recognizer step for the character currently offered by the owner.
    always_comb begin
        rec_nxt = R_ERR;
        case (rec_q)
            R_START: rec_nxt = is_digit ? R_DIG : R_ERR;
            R_DIG:   rec_nxt = is_digit ? R_ERR : R_SEP;
            R_SEP:   rec_nxt = is_digit ? R_DIG : R_ERR;
            default: rec_nxt = R_ERR;
        endcase
    end

    // Controller next state, grant, length/recognizer updates and readys.
    always_comb begin
        state_d   = state_q;
        rec_d     = rec_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        len_d     = len_q;
        in0_ready = 1'b0;
        in1_ready = 1'b0;
`ifdef STR_CHECK_SCHED_TIMEOUT_EN
        idle_cnt_d = idle_cnt_q;
        abort_d    = abort_q;
`endif
        case (state_q)
            IDLE: begin
                if (in0_valid || in1_valid) begin
                    // Tie goes to rr_ptr; a lone requester wins outright.
                    owner_d = (in0_valid && in1_valid) ? rr_ptr_q : in1_valid;
                    rec_d   = R_START;
                    len_d   = 8'd0;
                    state_d = STREAM;
`ifdef STR_CHECK_SCHED_TIMEOUT_EN
                    idle_cnt_d = 4'd15;
                    abort_d    = 1'b0;
`endif
                end
            end
            STREAM: begin
                in0_ready = ~owner_q;
                in1_ready = owner_q;
                if (xfer) begin
                    rec_d = rec_nxt;
                    len_d = (len_q == 8'hff) ? len_q : len_q + 8'd1;
                    if (sel_last) begin
                        state_d = REPORT;
                    end
`ifdef STR_CHECK_SCHED_TIMEOUT_EN
                    idle_cnt_d = 4'd15;
                end else if (idle_cnt_q == 4'd0) begin
                    abort_d = 1'b1;
                    state_d = REPORT;
                end else begin
                    idle_cnt_d = idle_cnt_q - 4'd1;
`endif
                end
            end
            REPORT: begin
                rr_ptr_d = ~owner_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            rec_q    <= R_START;
            rr_ptr_q <= 1'b0;
            owner_q  <= 1'b0;
            len_q    <= 8'd0;
`ifdef STR_CHECK_SCHED_TIMEOUT_EN
            idle_cnt_q <= 4'd15;
            abort_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rec_q    <= rec_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            len_q    <= len_d;
`ifdef STR_CHECK_SCHED_TIMEOUT_EN
            idle_cnt_q <= idle_cnt_d;
            abort_q    <= abort_d;
`endif
        end
    end

    assign res_valid = (state_q == REPORT);
    assign res_id    = res_valid & owner_q;
    assign res_len   = res_valid ? len_q : 8'd0;
    assign busy      = (state_q != IDLE);
`ifdef STR_CHECK_SCHED_TIMEOUT_EN
    assign res_ok    = res_valid && (rec_q == R_DIG) && !abort_q;
    assign res_abort = res_valid & abort_q;
`else
    assign res_ok    = res_valid && (rec_q == R_DIG);
    assign res_abort = 1'b0;
`endif

endmodule

// File: tb/tb_str_check_sched.sv
// Bench for str_check_sched: directed strings, a string-level reference model
// and a per-cycle compare process.
`timescale 1ns/1ps

module tb_str_check_sched;

    logic       clk = 1'b0;
    logic       clr;
    logic       in0_valid, in0_last, in0_ready;
    logic [7:0] in0_data;
    logic       in1_valid, in1_last, in1_ready;
    logic [7:0] in1_data;
    logic       res_valid, res_ok, res_id, res_abort, busy;
    logic [7:0] res_len;

    str_check_sched dut (
        .clk(clk), .clr(clr),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
        .res_valid(res_valid), .res_ok(res_ok), .res_id(res_id), .res_len(res_len),
        .res_abort(res_abort), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef byte bq_t[$];
    typedef struct {bit ok; bit id; int len; bit ab;} res_t;
    res_t log_q[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // String-level rule: odd length, digits at even positions, non-digits at odd.
    function automatic bit ref_ok(input bq_t q);
        if (q.size() == 0 || (q.size() % 2) == 0) return 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            bit d;
            d = (q[i] >= 8'h30) && (q[i] <= 8'h39);
            if (((i % 2) == 0) != d) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic int sat(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    // Model state: characters of the string in flight and the expected strobe.
    bq_t        mq;
    bit         mactive = 0;
    bit         mowner  = 0;
    int         midle   = 0;
    bit         ev = 0, eok = 0, eid = 0, eab = 0;
    logic [7:0] elen = 0;

    task automatic take(input bit id, input logic [7:0] d, input logic l);
        mq.push_back(d);
        mowner = id;
        midle  = 0;
        if (l) begin
            ev = 1; eok = ref_ok(mq); eid = id; elen = 8'(sat(mq.size())); eab = 0;
            mq.delete();
            mactive = 0;
        end else begin
            mactive = 1;
        end
    endtask

    // Per-cycle compare of DUT outputs against the model.
    always @(negedge clk) begin
        if (clr) begin
            chk("reset_outputs", {res_valid, res_ok, res_id, res_len, res_abort, busy, in0_ready, in1_ready}, 0);
            mq.delete(); mactive = 0; midle = 0; ev = 0;
        end else begin
            total++;
            if (res_valid !== ev ||
                (ev  && (res_ok !== eok || res_id !== eid || res_len !== elen || res_abort !== eab)) ||
                (!ev && (res_ok || res_id || res_len != 0 || res_abort))) begin
                bad++;
                $display("FAIL result: got v=%0b ok=%0b id=%0b len=%0d ab=%0b, expected v=%0b ok=%0b id=%0b len=%0d ab=%0b (t=%0t)",
                         res_valid, res_ok, res_id, res_len, res_abort, ev, eok, eid, elen, eab, $time);
            end
            if (res_valid) log_q.push_back('{res_ok, res_id, int'(res_len), res_abort});
            chk("ready_exclusive", int'(in0_ready && in1_ready), 0);
            ev = 0;
            if (in0_valid && in0_ready) take(1'b0, in0_data, in0_last);
            else if (in1_valid && in1_ready) take(1'b1, in1_data, in1_last);
            else if (mactive && !(mowner ? in1_valid : in0_valid)) begin
                midle++;
`ifdef STR_CHECK_SCHED_TIMEOUT_EN
                if (midle == 16) begin
                    ev = 1; eok = 0; eid = mowner; elen = 8'(sat(mq.size())); eab = 1;
                    mq.delete();
                    mactive = 0;
                end
`endif
            end
        end
    end

    task automatic set_in(input bit id, input logic v, input logic [7:0] d, input logic l);
        if (id) begin in1_valid = v; in1_data = d; in1_last = l; end
        else    begin in0_valid = v; in0_data = d; in0_last = l; end
    endtask

    // Offer each character until accepted; bounded wait per character.
    task automatic send(input bit id, input string s, input bit give_last);
        for (int i = 0; i < s.len(); i++) begin
            bit got;
            got = 0;
            set_in(id, 1'b1, s[i], give_last && (i == s.len() - 1));
            for (int w = 0; w < 400 && !got; w++) begin
                @(negedge clk);
                got = id ? in1_ready : in0_ready;
                @(posedge clk);
                #1;
            end
            if (!got) begin
                chk("send_wait_expired", 0, 1);
                break;
            end
        end
        set_in(id, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic chk_log(input string name, input int idx, input bit ok, input bit id, input int len, input bit ab);
        if (idx >= log_q.size()) begin
            chk({name, "_present"}, 0, 1);
        end else begin
            chk({name, "_ok"},  log_q[idx].ok,  ok);
            chk({name, "_id"},  log_q[idx].id,  id);
            chk({name, "_len"}, log_q[idx].len, len);
            chk({name, "_abort"}, log_q[idx].ab, ab);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got timeout, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        int base;
        string long_s;
        clr = 1'b1;
        set_in(1'b0, 1'b0, 8'h00, 1'b0);
        set_in(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_readys", {in0_ready, in1_ready}, 0);
        clr = 1'b0;

        // Pin the model with hand-computed answers.
        chk("model_1+2",  ref_ok(str2q("1+2")), 1);
        chk("model_12a3", ref_ok(str2q("12a3")), 0);
        chk("model_a",    ref_ok(str2q("a")), 0);
        chk("model_7-8",  ref_ok(str2q("7-8")), 1);
        chk("model_1+",   ref_ok(str2q("1+")), 0);

        base = log_q.size();
        send(1'b0, "1+2", 1'b1);
        repeat (3) @(posedge clk); #1;
        chk("s1_count", log_q.size() - base, 1);
        chk_log("s1", base, 1, 0, 3, 0);

        base = log_q.size();
        send(1'b1, "12a3", 1'b1);
        repeat (3) @(posedge clk); #1;
        send(1'b1, "a", 1'b1);
        repeat (3) @(posedge clk); #1;
        chk("s2_count", log_q.size() - base, 2);
        chk_log("s2a", base, 0, 1, 4, 0);
        chk_log("s2b", base + 1, 0, 1, 1, 0);

        pulse_clr();
        base = log_q.size();
        fork
            send(1'b0, "5", 1'b1);
            send(1'b1, "7-8", 1'b1);
        join
        repeat (3) @(posedge clk); #1;
        chk("s3_count", log_q.size() - base, 2);
        chk_log("s3a", base, 1, 0, 1, 0);
        chk_log("s3b", base + 1, 1, 1, 3, 0);

        long_s = "1";
        for (int i = 0; i < 150; i++) long_s = {long_s, ",1"};
        base = log_q.size();
        send(1'b0, long_s, 1'b1);
        repeat (3) @(posedge clk); #1;
        chk("s4_count", log_q.size() - base, 1);
        chk_log("s4", base, 1, 0, 255, 0);

        base = log_q.size();
        send(1'b0, "1+", 1'b0);
        clr = 1'b1;
        #1;
        chk("s5_busy_immediate", busy, 0);
        chk("s5_ready_immediate", in0_ready, 0);
        @(negedge clk);
        @(posedge clk); #1;
        clr = 1'b0;
        send(1'b0, "9", 1'b1);
        repeat (3) @(posedge clk); #1;
        chk("s5_count", log_q.size() - base, 1);
        chk_log("s5", base, 1, 0, 1, 0);

        base = log_q.size();
        send(1'b0, "1+", 1'b0);
        repeat (20) @(posedge clk); #1;
`ifdef STR_CHECK_SCHED_TIMEOUT_EN
        chk("s6_count", log_q.size() - base, 1);
        chk_log("s6", base, 0, 0, 2, 1);
        chk("s6_busy_after", busy, 0);
`else
        chk("s6_count", log_q.size() - base, 0);
        chk("s6_busy_held", busy, 1);
        pulse_clr();
`endif
        repeat (2) @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
